data_mem_ctrl: RTL and testbench



---
 rtl/data_mem_pkg.sv | 27 ++
 rtl/data_mem_lane_ext.sv | 18 +
 rtl/data_mem_ctrl.sv | 123 ++++++++++++
 tb/tb_data_mem_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared funct3 codes, FSM state encodings and access legality check
package data_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // An access is rejected when funct3 is not a legal load/store width,
    // when a half/word access is not naturally aligned, or when address
    // bits above the array are set.
    function automatic logic acc_err(input logic we, input logic [2:0] f3,
                                     input logic [1:0] a, input logic oor);
        logic legal, mis;
        legal = we ? (f3 == F3_B || f3 == F3_H || f3 == F3_W)
                   : (f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
        mis = ((f3 == F3_H || f3 == F3_HU) && a[0]) || (f3 == F3_W && a != 2'b00);
        return !legal || mis || oor;
    endfunction

endpackage

// File: rtl/data_mem_lane_ext.sv
// data_mem_lane_ext: selects the addressed byte/half of a word and sign/zero extends it
module data_mem_lane_ext
    import data_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    logic [31:0] sh;
    assign sh = word >> {addr, 3'b000};
    // LW relies on alignment having been checked, so sh equals word for it
    always_comb
        data = funct3 == F3_B  ? {{24{sh[7]}}, sh[7:0]}   :
               funct3 == F3_H  ? {{16{sh[15]}}, sh[15:0]} :
               funct3 == F3_BU ? {24'b0, sh[7:0]}         :
               funct3 == F3_HU ? {16'b0, sh[15:0]}        : sh;
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressed RV32 data memory with valid/ready requests and configurable read latency
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 10,
    parameter int READ_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);
    localparam int WW = $clog2(DEPTH_WORDS);
    localparam logic [1:0] LAT_INIT = 2'(READ_LAT > 1 ? READ_LAT - 2 : 0);

    logic [31:0]   mem [DEPTH_WORDS];
    logic [1:0]    state;
    logic [WW-1:0] clr_cnt;
    logic [1:0]    lat_cnt;
    logic [2:0]    q_f3;
    logic [1:0]    q_a;
    logic [31:0]   rd_word;
    logic          accept;
    logic          err_c;
    logic [WW-1:0] idx;
    logic [3:0]    be;
    logic [31:0]   wd;
    logic [31:0]   ext_word;
    logic [1:0]    ext_a;
    logic [2:0]    ext_f3;
    logic [31:0]   ext_out;

    assign req_ready = state == ST_IDLE;
    assign accept    = req_valid && req_ready;
    assign idx       = req_addr[WW+1:2];
    assign err_c     = acc_err(req_we, req_funct3, req_addr[1:0], (req_addr >> (WW + 2)) != '0);

    // Store lane enables and replicated write data so each lane sees its own bytes
    always_comb begin
        be = req_funct3 == F3_B ? 4'b0001 << req_addr[1:0] :
             req_funct3 == F3_H ? 4'b0011 << req_addr[1:0] : 4'b1111;
        wd = req_funct3 == F3_B ? {4{req_wdata[7:0]}} :
             req_funct3 == F3_H ? {2{req_wdata[15:0]}} : req_wdata;
    end

    // Extraction reads straight from the array for single-cycle loads, else from the held word
    always_comb begin
        ext_word = state == ST_IDLE ? mem[idx] : rd_word;
        ext_a    = state == ST_IDLE ? req_addr[1:0] : q_a;
        ext_f3   = state == ST_IDLE ? req_funct3 : q_f3;
    end

    data_mem_lane_ext u_ext (
        .word   (ext_word),
        .addr   (ext_a),
        .funct3 (ext_f3),
        .data   (ext_out)
    );

    // Array writes: zero sweep while clearing, lane-merged stores on accept; nothing in reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_CLEAR)
                mem[clr_cnt] <= '0;
            else if (accept && req_we && !err_c)
                for (int b = 0; b < 4; b++)
                    if (be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
        end
    end

    // Control FSM and registered response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_CLEAR;
            clr_cnt    <= '0;
            lat_cnt    <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == WW'(DEPTH_WORDS - 1)) state <= ST_IDLE;
                end
                ST_IDLE: if (accept) begin
                    q_f3    <= req_funct3;
                    q_a     <= req_addr[1:0];
                    rd_word <= mem[idx];
                    lat_cnt <= LAT_INIT;
                    if (req_we || err_c || READ_LAT == 1) begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= err_c;
                        resp_rdata <= (req_we || err_c) ? 32'b0 : ext_out;
                    end else begin
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (lat_cnt == 2'd0) begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= ext_out;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed checks of clear sweep, load/store lanes, errors, throughput and reset abort
module tb_data_mem_ctrl;
    localparam int LAT = 3;

    logic        clk = 0;
    logic        rst = 1;
    logic        req_valid = 0;
    logic        req_ready;
    logic        req_we = 0;
    logic [2:0]  req_funct3 = 0;
    logic [5:0]  req_addr = 0;
    logic [31:0] req_wdata = 0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_checks = 0;
    int n_fail = 0;

    data_mem_ctrl #(.DEPTH_WORDS(16), .ADDR_W(6), .READ_LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    // Issue one request and return the response and its latency in cycles after accept
    task automatic txn(input logic we, input logic [2:0] f3, input logic [5:0] a,
                       input logic [31:0] wdat, output logic [31:0] rd, output logic er, output int lat);
        int w;
        w = 0;
        @(negedge clk);
        while (!req_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        req_valid = 1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wdat;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = resp_rdata;
        er = resp_err;
    endtask

    // Release reset and count clock edges until req_ready rises, noting any stray response
    task automatic wait_clear(output int n, output logic seen);
        n = 0;
        seen = 0;
        while (n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            seen |= resp_valid;
            if (req_ready) break;
        end
    endtask

    task automatic test_reset;
        logic [31:0] rd; logic er, seen; int lat, n;
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (req_ready !== 0 || resp_valid !== 0 || resp_rdata !== 0 || resp_err !== 0) begin
            n_fail++;
            $display("FAIL reset_vals: ready=%b valid=%b rdata=%h err=%b, want 0 0 0 0", req_ready, resp_valid, resp_rdata, resp_err);
        end
        rst = 0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        wait_clear(n, seen);
        n_checks++;
        if (n !== 16) begin n_fail++; $display("FAIL clear_len: got %0d cycles, want 16", n); end
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL clear_resp: resp_valid seen during clear"); end
        txn(0, 3'b010, 6'h3C, 0, rd, er, lat);
        n_checks++;
        if (rd !== 32'h0 || er !== 0 || lat !== LAT) begin
            n_fail++; $display("FAIL lw_cleared: rd=%h err=%b lat=%0d, want 00000000 0 %0d", rd, er, lat, LAT);
        end
    endtask

    task automatic test_word_half;
        logic [31:0] rd; logic er; int lat;
        txn(1, 3'b010, 6'h08, 32'h12345678, rd, er, lat);
        n_checks++;
        if (rd !== 0 || er !== 0 || lat !== 1) begin
            n_fail++; $display("FAIL sw_resp: rd=%h err=%b lat=%0d, want 00000000 0 1", rd, er, lat);
        end
        txn(0, 3'b010, 6'h08, 0, rd, er, lat);
        n_checks++;
        if (rd !== 32'h12345678 || er !== 0 || lat !== LAT) begin
            n_fail++; $display("FAIL lw_08: rd=%h err=%b lat=%0d, want 12345678 0 %0d", rd, er, lat, LAT);
        end
        @(negedge clk);
        n_checks++;
        if (resp_valid !== 0 || resp_rdata !== 32'h12345678) begin
            n_fail++; $display("FAIL resp_hold: valid=%b rd=%h, want 0 12345678", resp_valid, resp_rdata);
        end
        txn(0, 3'b100, 6'h09, 0, rd, er, lat);
        n_checks++;
        if (rd !== 32'h56 || er !== 0) begin n_fail++; $display("FAIL lbu_09: rd=%h err=%b, want 00000056 0", rd, er); end
        txn(0, 3'b101, 6'h0A, 0, rd, er, lat);
        n_checks++;
        if (rd !== 32'h1234 || er !== 0) begin n_fail++; $display("FAIL lhu_0a: rd=%h err=%b, want 00001234 0", rd, er); end
        txn(0, 3'b001, 6'h0A, 0, rd, er, lat);
        n_checks++;
        if (rd !== 32'h1234) begin n_fail++; $display("FAIL lh_0a: rd=%h, want 00001234", rd); end
        txn(1, 3'b001, 6'h0A, 32'hFFFF_9ABC, rd, er, lat);
        txn(0, 3'b010, 6'h08, 0, rd, er, lat);
        n_checks++;
        if (rd !== 32'h9ABC5678) begin n_fail++; $display("FAIL sh_merge: rd=%h, want 9abc5678", rd); end
        txn(0, 3'b001, 6'h0A, 0, rd, er, lat);
        n_checks++;
        if (rd !== 32'hFFFF9ABC) begin n_fail++; $display("FAIL lh_sign: rd=%h, want ffff9abc", rd); end
    endtask

    task automatic test_byte;
        logic [31:0] rd; logic er; int lat;
        txn(1, 3'b000, 6'h03, 32'h0000_0080, rd, er, lat);
        txn(0, 3'b000, 6'h03, 0, rd, er, lat);
        n_checks++;
        if (rd !== 32'hFFFFFF80 || er !== 0) begin n_fail++; $display("FAIL lb_03: rd=%h err=%b, want ffffff80 0", rd, er); end
        txn(0, 3'b100, 6'h03, 0, rd, er, lat);
        n_checks++;
        if (rd !== 32'h80) begin n_fail++; $display("FAIL lbu_03: rd=%h, want 00000080", rd); end
        txn(0, 3'b010, 6'h00, 0, rd, er, lat);
        n_checks++;
        if (rd !== 32'h80000000) begin n_fail++; $display("FAIL lw_00: rd=%h, want 80000000", rd); end
    endtask

    task automatic test_errors;
        logic [31:0] rd; logic er; int lat;
        txn(1, 3'b001, 6'h01, 32'hBEEF, rd, er, lat);
        n_checks++;
        if (rd !== 0 || er !== 1 || lat !== 1) begin
            n_fail++; $display("FAIL sh_misalign: rd=%h err=%b lat=%0d, want 00000000 1 1", rd, er, lat);
        end
        txn(0, 3'b010, 6'h00, 0, rd, er, lat);
        n_checks++;
        if (rd !== 32'h80000000 || er !== 0) begin n_fail++; $display("FAIL no_write: rd=%h err=%b, want 80000000 0", rd, er); end
        txn(0, 3'b011, 6'h00, 0, rd, er, lat);
        n_checks++;
        if (rd !== 0 || er !== 1 || lat !== 1) begin
            n_fail++; $display("FAIL ld_f3_011: rd=%h err=%b lat=%0d, want 00000000 1 1", rd, er, lat);
        end
        txn(1, 3'b100, 6'h04, 32'h1, rd, er, lat);
        n_checks++;
        if (er !== 1) begin n_fail++; $display("FAIL st_f3_100: err=%b, want 1", er); end
        txn(0, 3'b010, 6'h06, 0, rd, er, lat);
        n_checks++;
        if (rd !== 0 || er !== 1) begin n_fail++; $display("FAIL lw_misalign: rd=%h err=%b, want 00000000 1", rd, er); end
        txn(0, 3'b010, 6'h04, 0, rd, er, lat);
        n_checks++;
        if (rd !== 0 || er !== 0) begin n_fail++; $display("FAIL err_clears: rd=%h err=%b, want 00000000 0", rd, er); end
    endtask

    task automatic test_back_to_back;
        int acc, rsp;
        acc = 0; rsp = 0;
        @(negedge clk);
        while (!req_ready) @(negedge clk);
        req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 6'h08;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            if (req_ready && req_valid) acc++;
            if (resp_valid) rsp++;
        end
        @(negedge clk);
        req_valid = 0;
        n_checks++;
        if (acc !== 4) begin n_fail++; $display("FAIL b2b_accepts: got %0d, want 4", acc); end
        n_checks++;
        if (rsp !== 4) begin n_fail++; $display("FAIL b2b_resps: got %0d, want 4", rsp); end
    endtask

    task automatic test_reset_abort;
        logic [31:0] rd; logic er, seen; int lat, n;
        txn(1, 3'b010, 6'h08, 32'hA5A5A5A5, rd, er, lat);
        @(negedge clk);
        while (!req_ready) @(negedge clk);
        req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 6'h08;
        @(posedge clk);
        @(negedge clk);
        rst = 1; req_valid = 1; req_we = 1; req_addr = 6'h10; req_wdata = 32'hFFFFFFFF;
        seen = resp_valid;
        @(posedge clk);
        @(negedge clk);
        seen |= resp_valid;
        rst = 0; req_valid = 0;
        wait_clear(n, er);
        seen |= er;
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL abort_resp: resp_valid issued for abandoned load"); end
        n_checks++;
        if (n !== 16) begin n_fail++; $display("FAIL abort_clear: got %0d cycles, want 16", n); end
        txn(0, 3'b010, 6'h10, 0, rd, er, lat);
        n_checks++;
        if (rd !== 0) begin n_fail++; $display("FAIL abort_store: rd=%h, want 00000000", rd); end
        txn(0, 3'b010, 6'h08, 0, rd, er, lat);
        n_checks++;
        if (rd !== 0) begin n_fail++; $display("FAIL abort_swept: rd=%h, want 00000000", rd); end
        @(negedge clk);
        while (!req_ready) @(negedge clk);
        rst = 1; req_valid = 1; req_we = 1; req_funct3 = 3'b010; req_addr = 6'h14; req_wdata = 32'h55;
        @(posedge clk);
        @(negedge clk);
        rst = 0; req_valid = 0;
        wait_clear(n, seen);
        txn(0, 3'b010, 6'h14, 0, rd, er, lat);
        n_checks++;
        if (rd !== 0) begin n_fail++; $display("FAIL idle_rst_store: rd=%h, want 00000000", rd); end
    endtask

    initial begin
        test_reset();
        test_word_half();
        test_byte();
        test_errors();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
